sensor_debouncer: RTL and testbench

//   Conditions the two raw parking-gate sensors (A, B) before the parking-entry FSM.
//   Per channel: synchronizer chain, then a stability counter.

---
 rtl/sensor_debouncer.sv | 117 +++++++++++
 tb/tb_sensor_debouncer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sensor_debouncer.sv
// Two-channel synchronizer + stability-counter debouncer for the parking-gate sensors.
// Optional macro DEBOUNCE_BYPASS_EN removes the counters so db follows the synchronizer output.

module sensor_debouncer_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic db,
    output logic press,
    output logic rel
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

`ifdef DEBOUNCE_BYPASS_EN

    // Pulses look one stage ahead so they line up with the cycle db changes.
    assign db = s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '1;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], raw_n};
            press <= s & ~sync[SYNC_STAGES-2];
            rel   <= ~s & sync[SYNC_STAGES-2];
        end
    end

`else

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '1;
            cnt   <= '0;
            db    <= 1'b1;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], raw_n};
            press <= 1'b0;
            rel   <= 1'b0;
            if (s == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db    <= s;
                cnt   <= '0;
                press <= ~s;
                rel   <= s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`endif

endmodule

module sensor_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btnA_n,
    input  logic btnB_n,
    output logic btnA_db,
    output logic btnB_db,
    output logic btnA_press,
    output logic btnA_release,
    output logic btnB_press,
    output logic btnB_release
);

    sensor_debouncer_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) chan_a (
        .clk  (clk),
        .reset(reset),
        .raw_n(btnA_n),
        .db   (btnA_db),
        .press(btnA_press),
        .rel  (btnA_release)
    );

    sensor_debouncer_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) chan_b (
        .clk  (clk),
        .reset(reset),
        .raw_n(btnB_n),
        .db   (btnB_db),
        .press(btnB_press),
        .rel  (btnB_release)
    );

endmodule

// File: tb/tb_sensor_debouncer.sv
// Directed self-checking bench for sensor_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Build with DEBOUNCE_BYPASS_EN defined to exercise the bypass path instead.

module tb_sensor_debouncer;

    logic clk = 1'b0;
    logic reset;
    logic btnA_n;
    logic btnB_n;
    logic btnA_db;
    logic btnB_db;
    logic btnA_press;
    logic btnA_release;
    logic btnB_press;
    logic btnB_release;

    int checks = 0;
    int errors = 0;

    sensor_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btnA_n      (btnA_n),
        .btnB_n      (btnB_n),
        .btnA_db     (btnA_db),
        .btnB_db     (btnB_db),
        .btnA_press  (btnA_press),
        .btnA_release(btnA_release),
        .btnB_press  (btnB_press),
        .btnB_release(btnB_release)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Outputs expected from an idle channel pair: both released, no pulses.
    task automatic check_idle(input string tag);
        check({tag, " A_db"}, btnA_db, 1'b1);
        check({tag, " B_db"}, btnB_db, 1'b1);
        check({tag, " A_press"}, btnA_press, 1'b0);
        check({tag, " A_release"}, btnA_release, 1'b0);
        check({tag, " B_press"}, btnB_press, 1'b0);
        check({tag, " B_release"}, btnB_release, 1'b0);
    endtask

    initial begin
        reset  = 1'b1;
        btnA_n = 1'b1;
        btnB_n = 1'b1;
        tick(3);
        check_idle("reset");
        reset = 1'b0;
        tick(1);
        check_idle("post_reset");

`ifdef DEBOUNCE_BYPASS_EN
        btnA_n = 1'b0;
        tick(1);
        btnA_n = 1'b1;
        check("byp e1 A_db", btnA_db, 1'b1);
        tick(1);
        check("byp e2 A_db", btnA_db, 1'b0);
        check("byp e2 A_press", btnA_press, 1'b1);
        check("byp e2 A_release", btnA_release, 1'b0);
        tick(1);
        check("byp e3 A_db", btnA_db, 1'b1);
        check("byp e3 A_press", btnA_press, 1'b0);
        check("byp e3 A_release", btnA_release, 1'b1);
        tick(1);
        check_idle("byp e4");
`else
        // Clean press on A, held 10 edges
        btnA_n = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            check("press_wait A_db", btnA_db, 1'b1);
            check("press_wait A_press", btnA_press, 1'b0);
        end
        tick(1);
        check("press e6 A_db", btnA_db, 1'b0);
        check("press e6 A_press", btnA_press, 1'b1);
        check("press e6 B_db", btnB_db, 1'b1);
        check("press e6 B_press", btnB_press, 1'b0);
        tick(1);
        check("press e7 A_db", btnA_db, 1'b0);
        check("press e7 A_press", btnA_press, 1'b0);
        tick(3);
        btnA_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            check("rel_wait A_db", btnA_db, 1'b0);
            check("rel_wait A_release", btnA_release, 1'b0);
        end
        tick(1);
        check("rel e6 A_db", btnA_db, 1'b1);
        check("rel e6 A_release", btnA_release, 1'b1);
        tick(1);
        check("rel e7 A_release", btnA_release, 1'b0);

        // 3-cycle glitch is rejected
        btnA_n = 1'b0;
        tick(3);
        btnA_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("glitch A_db", btnA_db, 1'b1);
            check("glitch A_press", btnA_press, 1'b0);
            tick(1);
        end

        // 4-cycle low is the shortest accepted press
        btnA_n = 1'b0;
        tick(4);
        btnA_n = 1'b1;
        tick(1);
        check("min e5 A_db", btnA_db, 1'b1);
        tick(1);
        check("min e6 A_db", btnA_db, 1'b0);
        check("min e6 A_press", btnA_press, 1'b1);
        tick(4);
        check("min e10 A_db", btnA_db, 1'b1);
        check("min e10 A_release", btnA_release, 1'b1);
        tick(4);
        check_idle("min_settle");

        // Both channels change together
        btnA_n = 1'b0;
        btnB_n = 1'b0;
        tick(5);
        check("both e5 A_db", btnA_db, 1'b1);
        check("both e5 B_db", btnB_db, 1'b1);
        tick(1);
        check("both e6 A_db", btnA_db, 1'b0);
        check("both e6 B_db", btnB_db, 1'b0);
        check("both e6 A_press", btnA_press, 1'b1);
        check("both e6 B_press", btnB_press, 1'b1);
        tick(4);
        btnA_n = 1'b1;
        btnB_n = 1'b1;
        tick(6);
        check("both rel A_db", btnA_db, 1'b1);
        check("both rel B_db", btnB_db, 1'b1);
        check("both rel A_release", btnA_release, 1'b1);
        check("both rel B_release", btnB_release, 1'b1);
        tick(1);
        check_idle("both_settle");

        // Reset mid-count discards the partial count
        btnB_n = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(1);
        check("rst_mid B_db", btnB_db, 1'b1);
        check("rst_mid B_press", btnB_press, 1'b0);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            check("rst_rel_wait B_db", btnB_db, 1'b1);
            check("rst_rel_wait B_press", btnB_press, 1'b0);
        end
        tick(1);
        check("rst_rel e6 B_db", btnB_db, 1'b0);
        check("rst_rel e6 B_press", btnB_press, 1'b1);
        check("rst_rel e6 A_db", btnA_db, 1'b1);
        tick(1);
        check("rst_rel e7 B_press", btnB_press, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
